// File: rtl/sr_latch_driver_if.sv
// Request/drive bundle between a requester and sr_latch_driver.
// q_fb/fb_err exist only when SR_DRV_READBACK_EN is defined.
interface sr_latch_driver_if;
  logic req_valid;
  logic req_level;
  logic req_force;
  logic req_ready;
  logic s;
  logic r;
  logic q_exp;
  logic busy;
  logic skip;
`ifdef SR_DRV_READBACK_EN
  logic q_fb;
  logic fb_err;

  modport master (
    output req_valid,
    output req_level,
    output req_force,
    output q_fb,
    input  req_ready,
    input  s,
    input  r,
    input  q_exp,
    input  busy,
    input  skip,
    input  fb_err
  );

  modport slave (
    input  req_valid,
    input  req_level,
    input  req_force,
    input  q_fb,
    output req_ready,
    output s,
    output r,
    output q_exp,
    output busy,
    output skip,
    output fb_err
  );
`else
  modport master (
    output req_valid,
    output req_level,
    output req_force,
    input  req_ready,
    input  s,
    input  r,
    input  q_exp,
    input  busy,
    input  skip
  );

  modport slave (
    input  req_valid,
    input  req_level,
    input  req_force,
    output req_ready,
    output s,
    output r,
    output q_exp,
    output busy,
    output skip
  );
`endif
endinterface

// File: rtl/sr_latch_driver.sv
// Turns level requests into width-controlled s/r pulses for an SR latch, with a recovery gap.
// Optional readback compare (q_fb vs q_exp on IDLE entry) enabled by SR_DRV_READBACK_EN.
module sr_latch_driver #(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 1
) (
  input logic              clk,
  input logic              rst,
  sr_latch_driver_if.slave bus
);

  localparam logic [7:0] PulseCnt = 8'(PULSE_W - 1);
  localparam logic [7:0] GapCnt   = (GAP_W == 0) ? 8'd0 : 8'(GAP_W - 1);

  typedef enum logic [1:0] {
    StInit,
    StPulse,
    StGap,
    StIdle
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       q_exp_q, q_exp_d;
  logic       skip_q, skip_d;
  logic       enter_idle;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s_d        = s_q;
    r_d        = r_q;
    q_exp_d    = q_exp_q;
    skip_d     = 1'b0;
    enter_idle = 1'b0;

    unique case (state_q)
      StInit: begin
        // Known starting point: always drive the latch to 0 first.
        s_d     = 1'b0;
        r_d     = 1'b1;
        cnt_d   = PulseCnt;
        state_d = StPulse;
      end
      StPulse: begin
        if (cnt_q == 8'd0) begin
          s_d = 1'b0;
          r_d = 1'b0;
          if (GAP_W == 0) begin
            state_d    = StIdle;
            enter_idle = 1'b1;
          end else begin
            cnt_d   = GapCnt;
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StGap: begin
        if (cnt_q == 8'd0) begin
          state_d    = StIdle;
          enter_idle = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StIdle: begin
        if (bus.req_valid) begin
          if (bus.req_force || (bus.req_level != q_exp_q)) begin
            s_d     = bus.req_level;
            r_d     = !bus.req_level;
            q_exp_d = bus.req_level;
            cnt_d   = PulseCnt;
            state_d = StPulse;
          end else begin
            skip_d = 1'b1;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= 8'd0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      q_exp_q <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      q_exp_q <= q_exp_d;
      skip_q  <= skip_d;
    end
  end

`ifdef SR_DRV_READBACK_EN
  logic fb_err_q, fb_err_d;

  // Sticky: once the latch disagreed with the expected level, only reset clears it.
  always_comb begin
    fb_err_d = fb_err_q;
    if (enter_idle && (bus.q_fb != q_exp_q)) begin
      fb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_err_q <= 1'b0;
    end else begin
      fb_err_q <= fb_err_d;
    end
  end

  assign bus.fb_err = fb_err_q;
`else
  logic unused_enter_idle;
  assign unused_enter_idle = enter_idle;
`endif

  assign bus.req_ready = (state_q == StIdle) && !rst;
  assign bus.busy      = (state_q != StIdle);
  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.q_exp     = q_exp_q;
  assign bus.skip      = skip_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: three instances (2/1, 1/0, 256/1) checked every cycle against a
// remaining-cycles model, plus directed literal checks. Readback checks follow SR_DRV_READBACK_EN.
module tb_sr_latch_driver;

  localparam int PW[3] = '{2, 1, 256};
  localparam int GW[3] = '{1, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid = 1'b0;
  logic level = 1'b0;
  logic frc = 1'b0;
  logic started = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_latch_driver_if bus0 ();
  sr_latch_driver_if bus1 ();
  sr_latch_driver_if bus2 ();

  sr_latch_driver #(.PULSE_W(2), .GAP_W(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  sr_latch_driver #(.PULSE_W(1), .GAP_W(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  sr_latch_driver #(.PULSE_W(256), .GAP_W(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  assign bus0.req_valid = valid;
  assign bus0.req_level = level;
  assign bus0.req_force = frc;
  assign bus1.req_valid = valid;
  assign bus1.req_level = level;
  assign bus1.req_force = frc;
  assign bus2.req_valid = valid;
  assign bus2.req_level = level;
  assign bus2.req_force = frc;

  logic [2:0] s_v, r_v, q_v, busy_v, skip_v, rdy_v;
  assign s_v    = {bus2.s, bus1.s, bus0.s};
  assign r_v    = {bus2.r, bus1.r, bus0.r};
  assign q_v    = {bus2.q_exp, bus1.q_exp, bus0.q_exp};
  assign busy_v = {bus2.busy, bus1.busy, bus0.busy};
  assign skip_v = {bus2.skip, bus1.skip, bus0.skip};
  assign rdy_v  = {bus2.req_ready, bus1.req_ready, bus0.req_ready};

`ifdef SR_DRV_READBACK_EN
  // Latch models on instances 0 and 2; instance 1 readback is stuck at 0.
  logic [2:0] latch_q = 3'b000;
  logic [2:0] fb_v, err_v;
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (s_v[i]) latch_q[i] <= 1'b1;
      else if (r_v[i]) latch_q[i] <= 1'b0;
    end
  end
  assign fb_v = {latch_q[2], 1'b0, latch_q[0]};
  assign bus0.q_fb = fb_v[0];
  assign bus1.q_fb = fb_v[1];
  assign bus2.q_fb = fb_v[2];
  assign err_v = {bus2.fb_err, bus1.fb_err, bus0.fb_err};
`endif

  // Model: m_left = cycles until ready returns; the pulse is active while m_left > GW.
  int   m_left[3];
  logic m_init[3], m_q[3], m_drive[3], m_skip[3], m_err[3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_init[i]  <= 1'b1;
        m_left[i]  <= 0;
        m_q[i]     <= 1'b0;
        m_drive[i] <= 1'b0;
        m_skip[i]  <= 1'b0;
        m_err[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_skip[i] <= 1'b0;
        if (m_init[i]) begin
          m_init[i]  <= 1'b0;
          m_left[i]  <= PW[i] + GW[i];
          m_drive[i] <= 1'b0;
        end else if (m_left[i] > 0) begin
          m_left[i] <= m_left[i] - 1;
`ifdef SR_DRV_READBACK_EN
          if (m_left[i] == 1 && fb_v[i] != m_q[i]) m_err[i] <= 1'b1;
`endif
        end else if (valid) begin
          if (frc || level != m_q[i]) begin
            m_q[i]     <= level;
            m_drive[i] <= level;
            m_left[i]  <= PW[i] + GW[i];
          end else begin
            m_skip[i] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        logic pulse;
        pulse = !m_init[i] && (m_left[i] > GW[i]);
        check($sformatf("cyc_s%0d", i), 32'(s_v[i]), 32'(pulse && m_drive[i]));
        check($sformatf("cyc_r%0d", i), 32'(r_v[i]), 32'(pulse && !m_drive[i]));
        check($sformatf("cyc_q%0d", i), 32'(q_v[i]), 32'(m_q[i]));
        check($sformatf("cyc_skip%0d", i), 32'(skip_v[i]), 32'(m_skip[i]));
        check($sformatf("cyc_rdy%0d", i), 32'(rdy_v[i]),
              32'(!m_init[i] && m_left[i] == 0 && !rst));
        check($sformatf("cyc_busy%0d", i), 32'(busy_v[i]), 32'(m_init[i] || m_left[i] != 0));
        check($sformatf("cyc_sr_excl%0d", i), 32'(s_v[i] && r_v[i]), 32'd0);
`ifdef SR_DRV_READBACK_EN
        check($sformatf("cyc_fberr%0d", i), 32'(err_v[i]), 32'(m_err[i]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until instance 0 accepts it; returns 1 ns after the accepting edge.
  task automatic send(input logic lv, input logic fc);
    bit done = 1'b0;
    valid = 1'b1;
    level = lv;
    frc   = fc;
    for (int k = 0; k < 600 && !done; k++) begin
      if (rdy_v[0]) done = 1'b1;
      tick();
    end
    valid = 1'b0;
    frc   = 1'b0;
    check("accept_in_time", 32'(done), 32'd1);
  endtask

  initial begin
    int cnt2;
    bit all_rdy;
    #1 rst = 1'b1;
    started = 1'b1;
    tick();
    check("rst_s", 32'(s_v[0]), 32'd0);
    check("rst_r", 32'(r_v[0]), 32'd0);
    check("rst_ready", 32'(rdy_v[0]), 32'd0);
    check("rst_busy", 32'(busy_v[0]), 32'd1);
    tick();
    tick();
    rst = 1'b0;

    // INIT pulse: r on cycles 1-2, ready from cycle 4
    tick();
    check("init_r_c1", 32'(r_v[0]), 32'd1);
    tick();
    check("init_r_c2", 32'(r_v[0]), 32'd1);
    tick();
    check("init_r_c3", 32'(r_v[0]), 32'd0);
    check("init_rdy_c3", 32'(rdy_v[0]), 32'd0);
    tick();
    check("init_rdy_c4", 32'(rdy_v[0]), 32'd1);
    check("init_q", 32'(q_v[0]), 32'd0);

    // Set then reset
    send(1'b1, 1'b0);
    check("set_s1", 32'(s_v[0]), 32'd1);
    check("set_q", 32'(q_v[0]), 32'd1);
    tick();
    check("set_s2", 32'(s_v[0]), 32'd1);
    tick();
    check("set_gap_s", 32'(s_v[0]), 32'd0);
    check("set_gap_rdy", 32'(rdy_v[0]), 32'd0);
    send(1'b0, 1'b0);
    check("clr_r1", 32'(r_v[0]), 32'd1);
    check("clr_s1", 32'(s_v[0]), 32'd0);
    check("clr_q", 32'(q_v[0]), 32'd0);
    tick();
    check("clr_r2", 32'(r_v[0]), 32'd1);
    tick();
    check("clr_r3", 32'(r_v[0]), 32'd0);

    // Redundant requests are skipped, one per cycle
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    check("skip_strobe", 32'(skip_v[0]), 32'd1);
    check("skip_no_s", 32'(s_v[0]), 32'd0);
    check("skip_rdy", 32'(rdy_v[0]), 32'd1);
    send(1'b1, 1'b0);
    check("skip_again", 32'(skip_v[0]), 32'd1);
    tick();
    check("skip_clear", 32'(skip_v[0]), 32'd0);

    // Forced request still pulses
    send(1'b1, 1'b1);
    check("force_s1", 32'(s_v[0]), 32'd1);
    check("force_noskip", 32'(skip_v[0]), 32'd0);
    tick();
    check("force_s2", 32'(s_v[0]), 32'd1);
    tick();
    check("force_s3", 32'(s_v[0]), 32'd0);

    // Reset during the second cycle of an s pulse
    send(1'b1, 1'b1);
    tick();
    check("mid_s_before", 32'(s_v[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_s_drop", 32'(s_v[0]), 32'd0);
    check("mid_q", 32'(q_v[0]), 32'd0);
    check("mid_busy", 32'(busy_v[0]), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check("mid_init_r1", 32'(r_v[0]), 32'd1);
    tick();
    check("mid_init_r2", 32'(r_v[0]), 32'd1);
    tick();
    check("mid_init_r3", 32'(r_v[0]), 32'd0);

    // Boundary widths: every instance idle, then one common set request
    all_rdy = 1'b0;
    for (int k = 0; k < 600 && !all_rdy; k++) begin
      if (&rdy_v) all_rdy = 1'b1;
      else tick();
    end
    check("all_ready", 32'(all_rdy), 32'd1);
    valid = 1'b1;
    level = 1'b1;
    tick();
    valid = 1'b0;
    cnt2 = 0;
    check("pw1_s", 32'(s_v[1]), 32'd1);
    check("pw1_rdy_low", 32'(rdy_v[1]), 32'd0);
    if (s_v[2]) cnt2++;
    tick();
    check("pw1_s_off", 32'(s_v[1]), 32'd0);
    check("pw1_rdy_back", 32'(rdy_v[1]), 32'd1);
    for (int k = 0; k < 300; k++) begin
      if (s_v[2]) cnt2++;
      tick();
    end
    check("pw256_len", 32'(cnt2), 32'd256);
    check("pw256_rdy", 32'(rdy_v[2]), 32'd1);

`ifdef SR_DRV_READBACK_EN
    check("fb_ok0", 32'(err_v[0]), 32'd0);
    check("fb_ok2", 32'(err_v[2]), 32'd0);
    check("fb_stuck1", 32'(err_v[1]), 32'd1);
    tick();
    check("fb_sticky1", 32'(err_v[1]), 32'd1);
    rst = 1'b1;
    #1;
    check("fb_rst_clear", 32'(err_v[1]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Drives the `s`/`r` inputs of an `sr_latch`. It turns level requests, delivered over a valid/ready handshake, into width-controlled set or reset pulses, with a mandatory recovery gap between pulses. It tracks the expected latch state and skips redundant pulses. It never drives `s` and `r` high together. After reset it forces the latch into a known state with an initial reset pulse.

## Interface
Parameters:
- `PULSE_W`, default 2: cycles each `s`/`r` pulse is held high. Legal range 1..256.
- `GAP_W`, default 1: idle cycles after each pulse before the next request is accepted. Legal range 0..256.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in 1: request present.
- `req_level` in 1: target latch level (1 = set, 0 = reset).
- `req_force` in 1: pulse even if `req_level` equals `q_exp`.
- `req_ready` out 1: request accepted on an edge where `req_valid && req_ready`.
- `s` out 1: set drive to the latch. Registered.
- `r` out 1: reset drive to the latch. Registered.
- `q_exp` out 1: expected latch output. Registered.
- `busy` out 1: high when the FSM is not in IDLE.
- `skip` out 1: one-cycle strobe when an accepted request needs no pulse. Registered.
- `q_fb` in 1: latch output readback, synchronous to `clk`. Present only with `SR_DRV_READBACK_EN`.
- `fb_err` out 1: sticky readback mismatch flag. Registered. Present only with `SR_DRV_READBACK_EN`.

## Operation
**FSM states:** INIT, PULSE, GAP, IDLE. The counter `cnt` is 8 bits.

**Reset:** while `rst` is high, the block is forced as follows.
- state = INIT, `cnt` = 0.
- `s` = 0, `r` = 0, `q_exp` = 0, `skip` = 0, `fb_err` = 0.
- `req_ready` = 0, `busy` = 1.
- A reset asserted mid-pulse drops `s`/`r` immediately (asynchronous) and restarts from INIT.

**INIT:** on the first edge after `rst` falls:
- `r` <= 1, `cnt` <= `PULSE_W`-1, go to PULSE.

**IDLE:** `req_ready` = 1. On an accepting edge:
- If `req_force`, or `req_level` != `q_exp`:
  - `s` <= `req_level`, `r` <= !`req_level`.
  - `q_exp` <= `req_level`.
  - `cnt` <= `PULSE_W`-1, go to PULSE.
- Otherwise:
  - `skip` <= 1 for one cycle.
  - Stay in IDLE, leave `q_exp` unchanged, `s`/`r` stay 0.

**PULSE:**
- If `cnt` == 0: `s` <= 0, `r` <= 0. Go to GAP with `cnt` <= `GAP_W`-1, or go directly to IDLE if `GAP_W` == 0.
- Otherwise: `cnt` decrements.

**GAP:**
- If `cnt` == 0: go to IDLE.
- Otherwise: `cnt` decrements.

**Output rules:**
- `req_ready` = (state == IDLE) && !`rst`.
- `busy` = (state != IDLE).

**Invariants:**
- `s` && `r` is never 1.
- At most one of `s`/`r` is high, and only in PULSE.
- `req_valid` seen outside IDLE is ignored. The requester holds the request until it is accepted.

## Timing
- Request accepted at edge N:
  - `s`/`r`/`q_exp` change after edge N.
  - The pulse is high for exactly `PULSE_W` cycles.
  - Then low for `GAP_W` cycles.
  - `req_ready` rises after edge N+`PULSE_W`+`GAP_W`.
- Request throughput:
  - Pulsing requests: one per `PULSE_W`+`GAP_W`+1 cycles.
  - Skipped (redundant) requests: one per cycle.
- After reset release:
  - `r` is high for cycles 1..`PULSE_W`.
  - `req_ready` first rises after edge `PULSE_W`+`GAP_W`+1.
- A simultaneous `req_force` with `req_level` == `q_exp` still produces a full pulse and no `skip`.

## Configuration
Macro `SR_DRV_READBACK_EN`.

- **Defined:**
  - `q_fb` and `fb_err` exist.
  - On every edge that transitions the FSM into IDLE, the block compares `q_fb` against `q_exp`.
  - On mismatch, `fb_err` <= 1.
  - `fb_err` stays high until `rst`.
- **Undefined:** the ports and the compare logic are absent. All other behaviour is identical.

## Test plan
- **Reset and INIT:** `rst` high for 3 cycles, then low, with `PULSE_W`=2, `GAP_W`=1 -> `s`=`r`=0 during reset; `r`=1 on cycles 1-2 after release; `req_ready`=1 from cycle 4; `q_exp`=0.
- **Set then reset:** request level 1, then level 0, back-to-back -> `s` high 2 cycles, gap 1 cycle, `r` high 2 cycles; `q_exp` goes 1 then 0; `s`&`r` never both 1.
- **Redundant and forced requests:** with `q_exp`=1, request level 1 -> `skip`=1 for one cycle, no pulse. With `req_force`=1 -> `s` pulses for 2 cycles, no `skip`.
- **Reset mid-pulse:** `rst` asserted during the second cycle of an `s` pulse -> `s`=0 immediately; after release the INIT `r` pulse repeats.
- **Boundary parameters:** `GAP_W`=0, `PULSE_W`=1 -> `req_ready` returns on the edge after the single pulse cycle. `PULSE_W`=256 -> the pulse lasts exactly 256 cycles.
- **Readback (`SR_DRV_READBACK_EN`):** latch model tied correctly -> `fb_err`=0. `q_fb` stuck at 0 after a set -> `fb_err`=1 on entry to IDLE and stays high until `rst`.
